// File: rtl/dram_sel_pkg.sv
// Shared types and default widths for the DRAM_L1 -> DRAM_catch selective copy sequencer.
package dram_sel_pkg;

  localparam int DSC_D_WIDTH = 4;
  localparam int DSC_A_WIDTH = 15;
  localparam int DSC_C_WIDTH = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sel_state_e;

endpackage

// File: rtl/dram_sel_copy_ctrl_wr_stage.sv
// Retire/compaction stage: tracks the outstanding read and writes selected words densely into DRAM_catch.
module dram_sel_wr_stage
  import dram_sel_pkg::*;
#(
  parameter int D_WIDTH = DSC_D_WIDTH,
  parameter int C_WIDTH = DSC_C_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_issue,
  input  logic [D_WIDTH-1:0] i_rq,
  input  logic               i_sel,
  output logic               o_drop,
  output logic               o_wce,
  output logic [C_WIDTH-1:0] o_wa,
  output logic [D_WIDTH-1:0] o_wd,
  output logic [C_WIDTH:0]   o_hit_count,
  output logic               o_overflow
);

  localparam int WP_W = C_WIDTH + 1;

  logic               r_vld;
  logic [WP_W-1:0]    r_wp;
  logic               r_wce;
  logic [C_WIDTH-1:0] r_wa;
  logic [D_WIDTH-1:0] r_wd;
  logic               r_overflow;
  logic               w_full;
  logic               w_take;

  // The extra MSB of the write pointer is set exactly when the catch is full.
  assign w_full = r_wp[C_WIDTH];
  assign w_take = r_vld & i_sel & ~w_full;
  assign o_drop = r_vld & i_sel & w_full;

  // Retire the read issued last cycle and commit it to the catch if selected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld      <= 1'b0;
      r_wp       <= '0;
      r_wce      <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_vld      <= i_issue;
      r_wp       <= '0;
      r_wce      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_vld <= i_issue;
      r_wce <= w_take;
      if (w_take) begin
        r_wa <= r_wp[C_WIDTH-1:0];
        r_wd <= i_rq;
        r_wp <= r_wp + WP_W'(1);
      end
      if (o_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // The dense write pointer doubles as the hit count.
  assign o_wce       = r_wce;
  assign o_wa        = r_wa;
  assign o_wd        = r_wd;
  assign o_hit_count = r_wp;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/dram_sel_copy_ctrl.sv
// Selective copy sequencer: sweeps a DRAM_L1 window and compacts selected words into DRAM_catch.
// Optional feature macro CATCH_FULL_STOP_EN: the first dropped word ends the scan early.
module dram_sel_copy_ctrl
  import dram_sel_pkg::*;
#(
  parameter int D_WIDTH = DSC_D_WIDTH,
  parameter int A_WIDTH = DSC_A_WIDTH,
  parameter int C_WIDTH = DSC_C_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic [A_WIDTH-1:0] cfg_first,
  input  logic [A_WIDTH-1:0] cfg_last,
  output logic               l1_rce,
  output logic [A_WIDTH-1:0] l1_ra,
  input  logic [D_WIDTH-1:0] l1_rq,
  input  logic               l1_sel,
  output logic               cat_wce,
  output logic [C_WIDTH-1:0] cat_wa,
  output logic [D_WIDTH-1:0] cat_wd,
  output logic               busy,
  output logic               done,
  output logic [C_WIDTH:0]   hit_count,
  output logic               overflow
);

`ifdef CATCH_FULL_STOP_EN
  localparam bit STOP_ON_DROP = 1'b1;
`else
  localparam bit STOP_ON_DROP = 1'b0;
`endif

  sel_state_e         r_state;
  sel_state_e         w_next;
  logic [A_WIDTH-1:0] r_addr;
  logic [A_WIDTH-1:0] w_addr;
  logic [A_WIDTH-1:0] r_last;
  logic [A_WIDTH-1:0] w_last;
  logic [A_WIDTH-1:0] r_ra;
  logic [A_WIDTH-1:0] w_ra;
  logic [A_WIDTH-1:0] w_issue_addr;
  logic               r_rce;
  logic               w_rce;
  logic               w_issue;
  logic               w_clr;
  logic               w_drop;
  logic               r_busy;
  logic               r_done;

  // Next-state and next read-port values.
  always_comb begin
    w_next       = r_state;
    w_addr       = r_addr;
    w_last       = r_last;
    w_ra         = r_ra;
    w_rce        = 1'b0;
    w_issue      = 1'b0;
    w_issue_addr = r_addr;
    w_clr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr  = 1'b1;
          w_last = cfg_last;
          if (cfg_last < cfg_first) begin
            w_next = S_DONE;
          end else begin
            w_next       = S_SCAN;
            w_addr       = cfg_first;
            w_ra         = cfg_first;
            w_issue_addr = cfg_first;
            w_issue      = ~pause;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SCAN: begin
        if (STOP_ON_DROP && w_drop) begin
          w_next = S_DRAIN;
        end else begin
          w_ra    = r_addr;
          w_issue = ~pause;
        end
      end
      // Only one read can be in flight; it retires alongside the DONE cycle.
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Issuing the last address ends the scan, so the counter never wraps.
    if (w_issue) begin
      w_rce = 1'b1;
      if (w_issue_addr == w_last) begin
        w_next = S_DRAIN;
      end else begin
        w_addr = w_issue_addr + A_WIDTH'(1);
      end
    end else begin
      w_rce = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_last  <= '0;
      r_ra    <= '0;
      r_rce   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr;
      r_last  <= w_last;
      r_ra    <= w_ra;
      r_rce   <= w_rce;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (r_state == S_DONE);
    end
  end

  dram_sel_wr_stage #(
    .D_WIDTH (D_WIDTH),
    .C_WIDTH (C_WIDTH)
  ) u_wr_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_issue     (r_rce),
    .i_rq        (l1_rq),
    .i_sel       (l1_sel),
    .o_drop      (w_drop),
    .o_wce       (cat_wce),
    .o_wa        (cat_wa),
    .o_wd        (cat_wd),
    .o_hit_count (hit_count),
    .o_overflow  (overflow)
  );

  assign l1_rce = r_rce;
  assign l1_ra  = r_ra;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
